atm_session_driver: RTL
=======================

# atm_session_driver

Transaction initiator for the ATM controller: it plays the customer and keypad side of the controller's input protocol. On a `start` request it presents the card, strobes four BCD PIN digits, waits a settle window, and strobes the amount. It then watches the controller's response flags and reports a single coded result. It sits between the test harness or host interface and the ATM controller, in the same clock domain.

## Interface
Parameters:
- `DIGIT_GAP`, default 1: idle cycles between consecutive strobes (card→digit, digit→digit); range 0..255.
- `SETTLE`, default 4: idle cycles between the last digit strobe and `monto_stb`; range 0..255.
- `RESP_TIMEOUT`, default 64: maximum cycles spent waiting for a response after `monto_stb`; range 1..65535.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a session; sampled only in IDLE.
- `pin_in`  in  16  four BCD digits, [15:12] sent first.
- `tipo_in`  in  1  1 = withdrawal, 0 = deposit.
- `monto_in`  in  32  transaction amount.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  3  0 DEP_OK, 1 WDR_OK, 2 INSUFFICIENT, 3 BLOCKED, 4 TIMEOUT, 5 BAD_PIN_FORMAT.
- `warn_seen`  out  1  sticky per session; set if `advertencia` is seen while busy.
- `tarjeta_recibida`  out  1  one-cycle card pulse.
- `tipo_trans`  out  1  latched `tipo_in`, held for the whole session.
- `digito_stb`  out  1  one-cycle digit strobe.
- `digito`  out  4  current digit; 0 when no strobe is active.
- `monto_stb`  out  1  one-cycle amount strobe.
- `monto`  out  32  latched `monto_in`, held for the whole session.
- `balance_actualizado`, `entregar_dinero`, `fondos_insuficientes`, `advertencia`, `bloqueo`  in  1 each  controller response flags.

## Operation
- **Outputs:** all are registered. On reset every output is 0, all counters are 0, state is IDLE.
- **States:** IDLE, CHECK, CARD, DGAP, DIGIT, SETTLE, AMOUNT, WAIT_RESP, DONE.
- **IDLE:**
  - `start` = 1 latches `pin_in`, `tipo_in` and `monto_in`, clears `warn_seen`, and moves to CHECK.
  - `start` while busy is ignored; no queueing.
- **CHECK:**
  - If any nibble of the latched PIN is greater than 9, go to DONE with result 5. No card pulse is issued.
  - Otherwise go to CARD.
- **CARD:** `tarjeta_recibida` = 1 for one cycle, then DGAP.
- **DGAP:** counts `DIGIT_GAP` idle cycles, then DIGIT. When `DIGIT_GAP` = 0, DGAP is skipped.
- **DIGIT:**
  - Asserts `digito_stb` for one cycle with `digito` = the current nibble; a 2-bit index selects [15:12], [11:8], [7:4], [3:0] in that order.
  - After index 3, go to SETTLE. Otherwise go to DGAP.
- **SETTLE:** counts `SETTLE` idle cycles, then AMOUNT.
- **AMOUNT:** `monto_stb` = 1 for one cycle, then WAIT_RESP.
- **WAIT_RESP:** samples the response flags each cycle, with priority `bloqueo` > `fondos_insuficientes` > `entregar_dinero` > `balance_actualizado`.
  - `bloqueo` → result 3.
  - `fondos_insuficientes` → result 2.
  - `entregar_dinero` → result 1.
  - `balance_actualizado` alone → result 0.
  - If the 16-bit timeout counter reaches `RESP_TIMEOUT` with no flag seen → result 4.
- **Early block:** `bloqueo` seen in any state from CARD through AMOUNT aborts immediately to DONE with result 3. No further strobes are issued.
- **Warning flag:** `advertencia` high in any busy cycle sets `warn_seen`. It stays set until the next accepted `start` or reset.
- **DONE:** `done` = 1 for one cycle, `busy` = 0 in the same cycle, return to IDLE. `result` and `warn_seen` hold until the next accepted `start`.
- **Reset mid-session:** returns to IDLE next edge; no `done` pulse, all strobes deasserted.

## Timing
- Take `start` sampled at edge 0.
- CHECK occupies cycle 1; `busy` = 1 from cycle 1.
- `tarjeta_recibida` is high in cycle 2.
- Digit k (k = 0..3) strobes in cycle 3 + `DIGIT_GAP` + k·(`DIGIT_GAP`+1).
  - With defaults: cycles 4, 6, 8, 10.
- `monto_stb` is high `SETTLE` + 1 cycles after the last digit strobe; with defaults, cycle 15.
- Response flags are sampled from cycle 16.
  - A flag first seen in cycle n gives `done` in cycle n+1.
  - With no flag, `done` is in cycle 16 + `RESP_TIMEOUT` (80 with defaults).
- Bad-PIN path: `done` in cycle 2.
- `digito_stb`, `tarjeta_recibida` and `monto_stb` are never high in the same cycle.
- Next `start` is accepted in the cycle after `done`.

## Test plan
- **Deposit:** `pin_in` = 16'h4756, `tipo_in` = 0, `monto_in` = 100; responder pulses `balance_actualizado` at cycle 17 → card at cycle 2, digits 4, 7, 5, 6 at cycles 4/6/8/10, `monto_stb` at 15, `done` at 18 with result 0, `warn_seen` = 0.
- **Withdrawal and insufficient funds:**
  - `tipo_in` = 1, `monto_in` = 500; responder raises `entregar_dinero` and `balance_actualizado` together → result 1, `tipo_trans` = 1 throughout.
  - Repeat with `fondos_insuficientes` → result 2.
- **Bad PIN format:** `pin_in` = 16'h47A6 → `done` at cycle 2 with result 5; no `tarjeta_recibida`, `digito_stb` or `monto_stb` ever asserted.
- **Timeout with warning:** no response flag, `advertencia` pulsed at cycle 9 → `done` at cycle 80 with result 4, `warn_seen` = 1.
- **Abort on block:** `bloqueo` raised at cycle 7 → no strobe after cycle 6, `done` at cycle 8 with result 3.
- **Reset and start gating:**
  - `rst` at cycle 9 → no `done`, all outputs 0 at cycle 10.
  - Second `start` pulsed while busy is ignored; a `start` in the cycle after `done` begins a new session.
  - `DIGIT_GAP` = 0 → digits at cycles 3, 4, 5, 6.

Source files
------------

// File: rtl/atm_session_driver_if.sv
// Bundles the session request, controller-facing strobes and controller response flags.
// master: the session driver; slave: the host/harness plus the ATM controller side.
interface atm_session_driver_if;
  logic        start;
  logic [15:0] pin_in;
  logic        tipo_in;
  logic [31:0] monto_in;
  logic        busy;
  logic        done;
  logic [2:0]  result;
  logic        warn_seen;
  logic        tarjeta_recibida;
  logic        tipo_trans;
  logic        digito_stb;
  logic [3:0]  digito;
  logic        monto_stb;
  logic [31:0] monto;
  logic        balance_actualizado;
  logic        entregar_dinero;
  logic        fondos_insuficientes;
  logic        advertencia;
  logic        bloqueo;

  modport master (
    input  start, pin_in, tipo_in, monto_in,
    input  balance_actualizado, entregar_dinero, fondos_insuficientes, advertencia, bloqueo,
    output busy, done, result, warn_seen,
    output tarjeta_recibida, tipo_trans, digito_stb, digito, monto_stb, monto
  );

  modport slave (
    output start, pin_in, tipo_in, monto_in,
    output balance_actualizado, entregar_dinero, fondos_insuficientes, advertencia, bloqueo,
    input  busy, done, result, warn_seen,
    input  tarjeta_recibida, tipo_trans, digito_stb, digito, monto_stb, monto
  );
endinterface

// File: rtl/atm_session_driver.sv
// Drives one ATM controller session per start request: card, four PIN digits, amount,
// then folds the controller's response flags into a single coded result.
module atm_session_driver #(
  parameter int DIGIT_GAP    = 1,
  parameter int SETTLE       = 4,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  atm_session_driver_if.master bus
);

  localparam logic [7:0]  GAP_LAST    = 8'(DIGIT_GAP - 32'sd1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 32'sd1);
  localparam logic [15:0] TO_LAST     = 16'(RESP_TIMEOUT - 32'sd1);

  localparam logic [2:0] RES_DEP_OK  = 3'd0;
  localparam logic [2:0] RES_WDR_OK  = 3'd1;
  localparam logic [2:0] RES_INSUF   = 3'd2;
  localparam logic [2:0] RES_BLOCKED = 3'd3;
  localparam logic [2:0] RES_TIMEOUT = 3'd4;
  localparam logic [2:0] RES_BAD_PIN = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CHECK     = 4'd1,
    S_CARD      = 4'd2,
    S_DGAP      = 4'd3,
    S_DIGIT     = 4'd4,
    S_SETTLE    = 4'd5,
    S_AMOUNT    = 4'd6,
    S_WAIT_RESP = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t      state_q;
  logic [15:0] pin_q;
  logic        tipo_q;
  logic [31:0] monto_q;
  logic [1:0]  idx_q;
  logic [7:0]  gap_cnt_q;
  logic [15:0] to_cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [2:0]  result_q;
  logic        warn_q;
  logic        card_q;
  logic        dstb_q;
  logic [3:0]  digit_q;
  logic        mstb_q;

  logic [1:0]  idx_inc_d;
  logic        early_abort_d;
  logic        resp_hit_d;
  logic [2:0]  resp_code_d;

  function automatic logic pin_is_bcd(input logic [15:0] p);
    return (p[15:12] <= 4'd9) && (p[11:8] <= 4'd9) && (p[7:4] <= 4'd9) && (p[3:0] <= 4'd9);
  endfunction

  function automatic logic [3:0] pin_nibble(input logic [15:0] p, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = p[15:12];
      2'd1:    nib = p[11:8];
      2'd2:    nib = p[7:4];
      2'd3:    nib = p[3:0];
      default: nib = 4'd0;
    endcase
    return nib;
  endfunction

  // Abort on block only while strobes are still being issued; later it is a normal response.
  always_comb begin
    idx_inc_d = idx_q + 2'd1;
    case (state_q)
      S_CARD, S_DGAP, S_DIGIT, S_SETTLE, S_AMOUNT: early_abort_d = bus.bloqueo;
      default:                                    early_abort_d = 1'b0;
    endcase
  end

  // Response priority: bloqueo > fondos_insuficientes > entregar_dinero > balance_actualizado.
  always_comb begin
    resp_hit_d  = 1'b1;
    resp_code_d = RES_DEP_OK;
    if (bus.bloqueo) begin
      resp_code_d = RES_BLOCKED;
    end else if (bus.fondos_insuficientes) begin
      resp_code_d = RES_INSUF;
    end else if (bus.entregar_dinero) begin
      resp_code_d = RES_WDR_OK;
    end else if (bus.balance_actualizado) begin
      resp_code_d = RES_DEP_OK;
    end else begin
      resp_hit_d  = 1'b0;
      resp_code_d = RES_DEP_OK;
    end
  end

  // Session FSM; every output is a register set on the edge that enters its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pin_q     <= 16'd0;
      tipo_q    <= 1'b0;
      monto_q   <= 32'd0;
      idx_q     <= 2'd0;
      gap_cnt_q <= 8'd0;
      to_cnt_q  <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 3'd0;
      warn_q    <= 1'b0;
      card_q    <= 1'b0;
      dstb_q    <= 1'b0;
      digit_q   <= 4'd0;
      mstb_q    <= 1'b0;
    end else begin
      card_q  <= 1'b0;
      dstb_q  <= 1'b0;
      digit_q <= 4'd0;
      mstb_q  <= 1'b0;
      done_q  <= 1'b0;
      if (busy_q && bus.advertencia) begin
        warn_q <= 1'b1;
      end
      if (early_abort_d) begin
        state_q  <= S_DONE;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        result_q <= RES_BLOCKED;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              pin_q    <= bus.pin_in;
              tipo_q   <= bus.tipo_in;
              monto_q  <= bus.monto_in;
              warn_q   <= 1'b0;
              result_q <= 3'd0;
              idx_q    <= 2'd0;
              busy_q   <= 1'b1;
              state_q  <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (!pin_is_bcd(pin_q)) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= RES_BAD_PIN;
            end else begin
              state_q <= S_CARD;
              card_q  <= 1'b1;
            end
          end
          S_CARD: begin
            gap_cnt_q <= 8'd0;
            if (DIGIT_GAP == 32'sd0) begin
              state_q <= S_DIGIT;
              dstb_q  <= 1'b1;
              digit_q <= pin_nibble(pin_q, idx_q);
            end else begin
              state_q <= S_DGAP;
            end
          end
          S_DGAP: begin
            if (gap_cnt_q == GAP_LAST) begin
              state_q <= S_DIGIT;
              dstb_q  <= 1'b1;
              digit_q <= pin_nibble(pin_q, idx_q);
            end else begin
              gap_cnt_q <= gap_cnt_q + 8'd1;
            end
          end
          S_DIGIT: begin
            gap_cnt_q <= 8'd0;
            if (idx_q == 2'd3) begin
              if (SETTLE == 32'sd0) begin
                state_q <= S_AMOUNT;
                mstb_q  <= 1'b1;
              end else begin
                state_q <= S_SETTLE;
              end
            end else begin
              idx_q <= idx_inc_d;
              if (DIGIT_GAP == 32'sd0) begin
                dstb_q  <= 1'b1;
                digit_q <= pin_nibble(pin_q, idx_inc_d);
              end else begin
                state_q <= S_DGAP;
              end
            end
          end
          S_SETTLE: begin
            if (gap_cnt_q == SETTLE_LAST) begin
              state_q <= S_AMOUNT;
              mstb_q  <= 1'b1;
            end else begin
              gap_cnt_q <= gap_cnt_q + 8'd1;
            end
          end
          S_AMOUNT: begin
            to_cnt_q <= 16'd0;
            state_q  <= S_WAIT_RESP;
          end
          S_WAIT_RESP: begin
            if (resp_hit_d) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= resp_code_d;
            end else if (to_cnt_q == TO_LAST) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= RES_TIMEOUT;
            end else begin
              to_cnt_q <= to_cnt_q + 16'd1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.result           = result_q;
  assign bus.warn_seen        = warn_q;
  assign bus.tarjeta_recibida = card_q;
  assign bus.tipo_trans       = tipo_q;
  assign bus.digito_stb       = dstb_q;
  assign bus.digito           = digit_q;
  assign bus.monto_stb        = mstb_q;
  assign bus.monto            = monto_q;

endmodule
